instr_loader: RTL and testbench
===============================

# instr_loader

Sequential instruction encoder and loader that generates the 16-bit instruction words consumed by the CPU's opcode decoder. It accepts one instruction per handshake as separate fields, packs the fields into the machine format, and writes the word into instruction memory at an auto-incrementing address. It sits between a host/boot source and the instruction-memory write port and is active only during program load.

## Interface
- `ADDR_W`, 8: instruction-memory address width in words.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin load session; sampled only in IDLE.
- `base_addr` in ADDR_W: first write address, latched on `start`.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: loader accepts; transfer when `in_valid & in_ready`.
- `in_op` in 4: opcode.
- `in_fa`, `in_fb`, `in_fc` in 4 each: operand fields. Meaning per opcode: R-type rd/rs/rt; LW/SW rt/rs/imm; BEQ rs/rt/offset; JMP target[11:8]/[7:4]/[3:0].
- `in_last` in 1: final instruction of session.
- `imem_we` out 1: memory write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 16: packed word.
- `busy` out 1: high in LOAD.
- `done` out 1: one-cycle pulse at session end.
- `err` out 1: sticky error, cleared by next accepted `start`.
- `count` out ADDR_W+1: words written in current/last session.

## Operation
- Packing: `imem_wdata = {in_op, in_fa, in_fb, in_fc}`, identical for all opcodes; field meaning is the sender's responsibility.
- Legal opcodes are 0x0–0x7 (ADD, SUB, AND, OR, LW, SW, BEQ, JMP). An opcode with bit 3 set is accepted (handshake completes) but not written: no `imem_we`, address and `count` unchanged, `err` set.
- FSM with states IDLE, LOAD, DONE:
  - IDLE: `in_ready`=0. `start` latches `base_addr` into the address counter and clears `count` and `err`, then goes to LOAD.
  - LOAD: `in_ready`=1. Each accepted legal word is written and the address increments modulo 2^ADDR_W. A transfer with `in_last`=1, legal or illegal, goes to DONE.
  - DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Overflow: when `count` reaches 2^ADDR_W, the session is full. A further legal word is not written, `err` is set, and the FSM goes to DONE regardless of `in_last`.
- `start` outside IDLE is ignored.
- If `start` and `in_valid` are high in the same IDLE cycle, there is no transfer because `in_ready` is 0.

## Timing
- `imem_we`, `imem_addr` and `imem_wdata` are registered and appear the cycle after the accepting edge.
- `imem_we` is high for exactly one cycle per legal word. Throughput is one word per cycle.
- `done` rises the cycle after the last transfer, which is the same cycle as that word's `imem_we`.
- `busy` and `in_ready` fall in the same DONE cycle.
- Reset values: state IDLE; `in_ready`, `imem_we`, `busy`, `done` and `err` are 0; `imem_addr`, `imem_wdata` and `count` are 0; checksum is 0.
- Reset asserted mid-LOAD aborts immediately. Any pending write is dropped. No `done` pulse follows.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` out 16, the running XOR of every word written in the session.
  - `checksum` clears on accepted `start` and updates in the same cycle as `imem_we`.
- Undefined: no port and no checksum logic.

## Structure
- The shared CPU package holds:
  - the opcode constants (OP_ADD=0x0 … OP_JMP=0x7) that the control decoder also uses;
  - INSTR_W=16 and the field bit positions;
  - the FSM state enum.
- One sub-module, `instr_pack`, is combinational: field packing plus legality check. It is reused by the bench's expected-word model.

## Test plan
- `base_addr`=0x10, three legal words (ADD 1,2,3; LW 4,5,7; JMP 0xABC with `in_last`) -> writes 0x0123@0x10, 0x4457@0x11, 0x7ABC@0x12; `done` one cycle after the third; `count`=3; `err`=0.
- Illegal op 0x9 between two legal words -> the second legal word goes to `base_addr`+1; `err`=1; `count`=2; next `start` clears `err`.
- ADDR_W=2, `base_addr`=2, five words -> addresses 2,3,0,1 written; fifth word dropped; `err`=1; `done`; `count`=4.
- `in_valid` toggled randomly, back-to-back bursts -> no lost or duplicated writes; one `imem_we` per legal transfer.
- `rst_n` low mid-LOAD -> all outputs return to reset values asynchronously; no `done`; IDLE after release.
- With `INSTR_LOADER_CHECKSUM_EN`, words 0x0123 and 0x4457 -> `checksum`=0x4574.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared CPU package: opcode constants used by the loader and the control
// decoder, instruction word geometry, and the loader FSM state encoding.
package instr_loader_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;

  // Bit positions of the four fields inside an instruction word.
  localparam int OP_LSB = 12;
  localparam int FA_LSB = 8;
  localparam int FB_LSB = 4;
  localparam int FC_LSB = 0;

  // Any opcode with this bit set lies outside the defined instruction set.
  localparam int OP_ILLEGAL_BIT = 3;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [FIELD_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_LW  = 4'h4,
    OP_SW  = 4'h5,
    OP_BEQ = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(input field_t op);
    return !op[OP_ILLEGAL_BIT];
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host-side field handshake plus instruction-memory write port of the loader.
// Optional checksum output exists only when INSTR_LOADER_CHECKSUM_EN is defined.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  field_t            in_op;
  field_t            in_fa;
  field_t            in_fb;
  field_t            in_fc;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  instr_t            imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;
`ifdef INSTR_LOADER_CHECKSUM_EN
  instr_t            checksum;
`endif

  // Host / boot source side.
  modport master (
`ifdef INSTR_LOADER_CHECKSUM_EN
    input  checksum,
`endif
    output start, base_addr, in_valid, in_op, in_fa, in_fb, in_fc, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

  // Loader side.
  modport slave (
`ifdef INSTR_LOADER_CHECKSUM_EN
    output checksum,
`endif
    input  start, base_addr, in_valid, in_op, in_fa, in_fb, in_fc, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

endinterface

// File: rtl/instr_loader_pack.sv
// instr_pack: combinational field packer and opcode legality check.
// Packing is identical for every opcode; field meaning belongs to the sender.
module instr_pack
  import instr_loader_pkg::*;
(
  input  field_t op_i,
  input  field_t fa_i,
  input  field_t fb_i,
  input  field_t fc_i,
  output instr_t word_o,
  output logic   legal_o
);

  // Place each field at its fixed position in the machine word.
  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    word_o = '0;
    word_o[OP_LSB +: FIELD_W] = op_i;
    word_o[FA_LSB +: FIELD_W] = fa_i;
    word_o[FB_LSB +: FIELD_W] = fb_i;
    word_o[FC_LSB +: FIELD_W] = fc_i;
  end

  assign legal_o = op_is_legal(op_i);

endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts one instruction per handshake, packs it and writes it
// into instruction memory at an auto-incrementing address.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds a running XOR of the
// words written in the current session.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_loader_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  instr_t            wdata_q, wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  instr_t            cks_q, cks_d;
`endif

  instr_t word;
  logic   legal;
  logic   accept;
  logic   full;
  logic   do_write;

  instr_pack u_pack (
    .op_i    (bus.in_op),
    .fa_i    (bus.in_fa),
    .fb_i    (bus.in_fb),
    .fc_i    (bus.in_fc),
    .word_o  (word),
    .legal_o (legal)
  );

  assign accept   = bus.in_valid && (state_q == ST_LOAD);
  // Top bit of count set means 2^ADDR_W words written: the session is full.
  assign full     = count_q[ADDR_W];
  assign do_write = accept && legal && !full;

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a last transfer or a legal word arriving when full ends the session.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: if (accept && (bus.in_last || (legal && full))) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: session init on start, one write per legal accepted word.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    if (state_q == ST_IDLE && bus.start) begin
      ptr_d   = bus.base_addr;
      count_d = '0;
      err_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_d   = '0;
`endif
    end
    if (accept) begin
      if (do_write) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
        cks_d   = cks_q ^ word;
`endif
      end else begin
        // Illegal opcode, or legal word with no room left: dropped and flagged.
        err_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset drops any write still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.busy       = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.count      = count_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign bus.checksum   = cks_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: table-driven sessions on an ADDR_W=8 instance,
// plus hand-written overflow (ADDR_W=2 instance), random-valid burst and
// mid-load reset sequences. Checksum checks compile in with
// INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  instr_loader_if #(.ADDR_W(8)) if_a ();
  instr_loader_if #(.ADDR_W(2)) if_b ();

  instr_loader #(.ADDR_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  instr_loader #(.ADDR_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        first;
    logic [7:0]  base;
    logic [3:0]  op, fa, fb, fc;
    logic        last;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [8:0]  exp_count;
    logic [15:0] exp_cks;
  } vec_t;

  vec_t vecs[6];

  logic [23:0] wlog[$];

  // Write monitor for the ADDR_W=8 instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && if_a.imem_we === 1'b1) wlog.push_back({if_a.imem_addr, if_a.imem_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] base);
    if_a.start     = 1'b1;
    if_a.base_addr = base;
    if_a.in_valid  = 1'b0;
    tick();
    if_a.start = 1'b0;
    check("start_busy", if_a.busy, 1);
    check("start_ready", if_a.in_ready, 1);
    check("start_err_clr", if_a.err, 0);
    check("start_count_clr", if_a.count, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("start_cks_clr", if_a.checksum, 0);
`endif
  endtask

  function automatic logic [15:0] rword(input int i);
    return {1'b0, 3'(i), 4'(i), 4'(15 - i), 4'(i + 1)};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] w;
    int idx, cyc;
    logic v, saw_done;

    //               first base   op    fa    fb    fc    last we  addr   data      err cnt  cks
    vecs[0] = '{1'b1, 8'h10, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 8'h10, 16'h0123, 1'b0, 9'd1, 16'h0123};
    vecs[1] = '{1'b0, 8'h00, 4'h4, 4'h4, 4'h5, 4'h7, 1'b0, 1'b1, 8'h11, 16'h4457, 1'b0, 9'd2, 16'h4574};
    vecs[2] = '{1'b0, 8'h00, 4'h7, 4'hA, 4'hB, 4'hC, 1'b1, 1'b1, 8'h12, 16'h7ABC, 1'b0, 9'd3, 16'h3FC8};
    vecs[3] = '{1'b1, 8'h40, 4'h0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b1, 8'h40, 16'h0012, 1'b0, 9'd1, 16'h0012};
    vecs[4] = '{1'b0, 8'h00, 4'h9, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 9'd1, 16'h0012};
    vecs[5] = '{1'b0, 8'h00, 4'h5, 4'h5, 4'h6, 4'h7, 1'b1, 1'b1, 8'h41, 16'h5567, 1'b1, 9'd2, 16'h5575};

    rst_n = 1'b0;
    {if_a.start, if_a.base_addr, if_a.in_valid, if_a.in_op, if_a.in_fa, if_a.in_fb, if_a.in_fc, if_a.in_last} = '0;
    {if_b.start, if_b.base_addr, if_b.in_valid, if_b.in_op, if_b.in_fa, if_b.in_fb, if_b.in_fc, if_b.in_last} = '0;

    // Reset values.
    tick();
    check("rst_ready", if_a.in_ready, 0);
    check("rst_we", if_a.imem_we, 0);
    check("rst_busy", if_a.busy, 0);
    check("rst_done", if_a.done, 0);
    check("rst_err", if_a.err, 0);
    check("rst_addr", if_a.imem_addr, 0);
    check("rst_wdata", if_a.imem_wdata, 0);
    check("rst_count", if_a.count, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("rst_cks", if_a.checksum, 0);
`endif
    #2 rst_n = 1'b1;
    tick();

    // Table-driven sessions: legal sequence, then illegal opcode mid-session.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].first) start_a(vecs[i].base);
      if_a.in_valid = 1'b1;
      if_a.in_op    = vecs[i].op;
      if_a.in_fa    = vecs[i].fa;
      if_a.in_fb    = vecs[i].fb;
      if_a.in_fc    = vecs[i].fc;
      if_a.in_last  = vecs[i].last;
      tick();
      check($sformatf("v%0d_we", i), if_a.imem_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i), if_a.imem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_data", i), if_a.imem_wdata, vecs[i].exp_data);
      end
      check($sformatf("v%0d_err", i), if_a.err, vecs[i].exp_err);
      check($sformatf("v%0d_count", i), if_a.count, vecs[i].exp_count);
      check($sformatf("v%0d_done", i), if_a.done, vecs[i].last);
`ifdef INSTR_LOADER_CHECKSUM_EN
      check($sformatf("v%0d_cks", i), if_a.checksum, vecs[i].exp_cks);
`endif
      if (vecs[i].last) begin
        check($sformatf("v%0d_busy_fall", i), if_a.busy, 0);
        check($sformatf("v%0d_ready_fall", i), if_a.in_ready, 0);
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
        tick();
        check($sformatf("v%0d_done_1cyc", i), if_a.done, 0);
      end
    end

    // Overflow on ADDR_W=2: base 2, five legal words, no in_last.
    if_b.start     = 1'b1;
    if_b.base_addr = 2'd2;
    tick();
    if_b.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if_b.in_valid = 1'b1;
      if_b.in_op    = 4'(k);
      if_b.in_fa    = 4'(k);
      if_b.in_fb    = 4'h0;
      if_b.in_fc    = 4'h0;
      if_b.in_last  = 1'b0;
      tick();
      if (k < 4) begin
        check($sformatf("ovf%0d_we", k), if_b.imem_we, 1);
        check($sformatf("ovf%0d_addr", k), if_b.imem_addr, 32'((2 + k) % 4));
        check($sformatf("ovf%0d_data", k), if_b.imem_wdata, {16'h0, 4'(k), 4'(k), 8'h00});
        check($sformatf("ovf%0d_count", k), if_b.count, 32'(k + 1));
        check($sformatf("ovf%0d_done", k), if_b.done, 0);
      end else begin
        check("ovf_drop_we", if_b.imem_we, 0);
        check("ovf_err", if_b.err, 1);
        check("ovf_done", if_b.done, 1);
        check("ovf_count", if_b.count, 4);
      end
    end
    if_b.in_valid = 1'b0;
    tick();
    check("ovf_done_1cyc", if_b.done, 0);

    // Random in_valid burst; start held with a different base must be ignored,
    // and start with in_valid in IDLE must not transfer.
    wlog.delete();
    if_a.start     = 1'b1;
    if_a.base_addr = 8'h80;
    if_a.in_valid  = 1'b1;
    w = rword(0);
    {if_a.in_op, if_a.in_fa, if_a.in_fb, if_a.in_fc} = w;
    if_a.in_last = 1'b0;
    tick();
    check("idle_no_xfer_we", if_a.imem_we, 0);
    check("idle_no_xfer_cnt", if_a.count, 0);
    check("rand_err_clr", if_a.err, 0);
    if_a.base_addr = 8'hEE;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      v = 1'($urandom_range(1, 0));
      w = rword(idx);
      if_a.in_valid = v;
      {if_a.in_op, if_a.in_fa, if_a.in_fb, if_a.in_fc} = w;
      if_a.in_last = (idx == 7);
      tick();
      cyc++;
      if (v) idx++;
    end
    check("rand_budget", idx, 8);
    if_a.in_valid = 1'b0;
    if_a.in_last  = 1'b0;
    if_a.start    = 1'b0;
    check("rand_done", if_a.done, 1);
    check("rand_count", if_a.count, 8);
    tick();
    check("rand_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size())
        check($sformatf("rand_w%0d", i), wlog[i], {8'(8'h80 + i), rword(i)});
    end

    // Reset mid-LOAD with a write pending and another transfer offered.
    start_a(8'h30);
    if_a.in_valid = 1'b1;
    {if_a.in_op, if_a.in_fa, if_a.in_fb, if_a.in_fc} = 16'h1111;
    tick();
    check("pre_rst_we", if_a.imem_we, 1);
    {if_a.in_op, if_a.in_fa, if_a.in_fb, if_a.in_fc} = 16'h2222;
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", if_a.imem_we, 0);
    check("arst_addr", if_a.imem_addr, 0);
    check("arst_wdata", if_a.imem_wdata, 0);
    check("arst_count", if_a.count, 0);
    check("arst_busy", if_a.busy, 0);
    check("arst_ready", if_a.in_ready, 0);
    check("arst_done", if_a.done, 0);
    check("arst_err", if_a.err, 0);
    if_a.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_a.done !== 1'b0) saw_done = 1'b1;
    end
    check("post_rst_no_done", saw_done, 0);
    check("post_rst_idle", if_a.in_ready, 0);
    check("post_rst_busy", if_a.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
